// File: rtl/hazard_pkg.sv
// Shared opcode constants, forward-select encodings and the per-stage write record
// used by the ID/EX hazard scoreboard.
package hazard_pkg;

  localparam int unsigned REG_AW_DFLT = 3;
  localparam int unsigned OPC_W_DFLT  = 4;
  localparam int unsigned FWD_W       = 2;

  localparam logic [OPC_W_DFLT-1:0] OPC_NOR   = 4'b0000;
  localparam logic [OPC_W_DFLT-1:0] OPC_NAND  = 4'b0001;
  localparam logic [OPC_W_DFLT-1:0] OPC_LW    = 4'b0010;
  localparam logic [OPC_W_DFLT-1:0] OPC_SW    = 4'b0011;
  localparam logic [OPC_W_DFLT-1:0] OPC_XNORI = 4'b0111;
  localparam logic [OPC_W_DFLT-1:0] OPC_ADD   = 4'b1111;

  localparam logic [FWD_W-1:0] FWD_RF    = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic                   valid;
    logic [REG_AW_DFLT-1:0] rd;
    logic                   writes_rd;
    logic                   is_load;
  } stage_rec_t;

  // A used source depends on a record that is live and writes the same register.
  function automatic logic src_match(input logic used, input stage_rec_t rec,
                                     input logic [REG_AW_DFLT-1:0] src);
    return used & rec.valid & rec.writes_rd & (rec.rd == src);
  endfunction

endpackage

// File: rtl/hazard_opclass.sv
// Opcode decode into register-usage classes; unknown opcodes behave as NOPs.
module hazard_opclass
  import hazard_pkg::*;
#(
  parameter int unsigned OPC_W = OPC_W_DFLT
) (
  input  logic [OPC_W-1:0] opcode,
  output logic             writes_rd_c,
  output logic             uses_rs1_c,
  output logic             uses_rs2_c,
  output logic             is_load_c
);

  always_comb begin
    writes_rd_c = 1'b0;
    uses_rs1_c  = 1'b0;
    uses_rs2_c  = 1'b0;
    is_load_c   = 1'b0;
    case (opcode)
      OPC_W'(OPC_NOR), OPC_W'(OPC_NAND), OPC_W'(OPC_ADD): begin
        writes_rd_c = 1'b1;
        uses_rs1_c  = 1'b1;
        uses_rs2_c  = 1'b1;
      end
      OPC_W'(OPC_LW): begin
        writes_rd_c = 1'b1;
        uses_rs1_c  = 1'b1;
        is_load_c   = 1'b1;
      end
      OPC_W'(OPC_XNORI): begin
        writes_rd_c = 1'b1;
        uses_rs1_c  = 1'b1;
      end
      OPC_W'(OPC_SW): begin
        uses_rs1_c  = 1'b1;
        uses_rs2_c  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID->EX issue/hazard controller tracking writes in EX, MEM and WB.
// HAZARD_FWD_EN enables forwarding selects and load-use-only stalls; otherwise stall until retire.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DFLT,
  parameter int unsigned OPC_W  = OPC_W_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [OPC_W-1:0]  id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  output logic              id_ready,
  input  logic              mem_stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [1:0]        ex_fwd_a_sel,
  output logic [1:0]        ex_fwd_b_sel
);

  stage_rec_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [FWD_W-1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  logic writes_rd_c, uses_rs1_c, uses_rs2_c, is_load_c;
  logic hazard_c;
  logic [FWD_W-1:0] fwd_a_c, fwd_b_c;
  logic a_ex_c, b_ex_c, a_mem_c, b_mem_c;

  hazard_opclass #(.OPC_W(OPC_W)) u_opclass (
    .opcode      (id_opcode),
    .writes_rd_c (writes_rd_c),
    .uses_rs1_c  (uses_rs1_c),
    .uses_rs2_c  (uses_rs2_c),
    .is_load_c   (is_load_c)
  );

  assign a_ex_c  = src_match(uses_rs1_c, ex_q,  REG_AW_DFLT'(id_rs1));
  assign b_ex_c  = src_match(uses_rs2_c, ex_q,  REG_AW_DFLT'(id_rs2));
  assign a_mem_c = src_match(uses_rs1_c, mem_q, REG_AW_DFLT'(id_rs1));
  assign b_mem_c = src_match(uses_rs2_c, mem_q, REG_AW_DFLT'(id_rs2));

`ifdef HAZARD_FWD_EN
  // Only a load still in EX cannot be forwarded; the youngest producer wins.
  assign hazard_c = ex_q.is_load & (a_ex_c | b_ex_c);
  assign fwd_a_c  = a_ex_c ? FWD_EXMEM : (a_mem_c ? FWD_MEMWB : FWD_RF);
  assign fwd_b_c  = b_ex_c ? FWD_EXMEM : (b_mem_c ? FWD_MEMWB : FWD_RF);
`else
  logic a_wb_c, b_wb_c;
  assign a_wb_c   = src_match(uses_rs1_c, wb_q, REG_AW_DFLT'(id_rs1));
  assign b_wb_c   = src_match(uses_rs2_c, wb_q, REG_AW_DFLT'(id_rs2));
  assign hazard_c = a_ex_c | b_ex_c | a_mem_c | b_mem_c | a_wb_c | b_wb_c;
  assign fwd_a_c  = FWD_RF;
  assign fwd_b_c  = FWD_RF;
`endif

  assign id_ready = rst_n & id_valid & ~mem_stall & ~hazard_c & ~flush;

  // Advance the tracked pipeline unless memory is stalled; a non-issue injects a bubble.
  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (!mem_stall) begin
      wb_d    = mem_q;
      mem_d   = ex_q;
      ex_d    = '0;
      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
      if (id_ready) begin
        ex_d.valid     = 1'b1;
        ex_d.rd        = REG_AW_DFLT'(id_rd);
        ex_d.writes_rd = writes_rd_c;
        ex_d.is_load   = is_load_c;
        fwd_a_d        = fwd_a_c;
        fwd_b_d        = fwd_b_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_fwd_a_sel = fwd_a_q;
  assign ex_fwd_b_sel = fwd_b_q;

endmodule
